action_encoder: RTL and testbench
=================================

// Module: action_encoder
// PURPOSE
//  Inverse of the action-index -> one-hot enable decoder. Collects 16 per-action
//  event lines (done/request pulses from enabled action units), queues them as
//  sticky pending bits, and returns them one at a time as a 4-bit action index
//  on a registered valid/ready stream. Round-robin selection gives every action
//  fair service. Sits between the action units and the learning controller.
// PARAMETERS
//  N      16            number of action lines (power of two, >=2)
//  IDX_W  $clog2(N)=4   index width; derived, never overridden
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_req     in   N        event pulses, one bit per action, any number per cycle
//  out_valid  out  1        out_idx holds a granted action
//  out_ready  in   1        consumer accepts out_idx when out_valid&&out_ready
//  out_idx    out  IDX_W    granted action index
//  pend_cnt   out  IDX_W+1  popcount of pending bits (registered)
//  ovf        out  1        sticky: event lost (bit already pending)
//  clr_ovf    in   1        synchronous clear of ovf
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): pending=0, out_valid=0,
//   out_idx=0, pend_cnt=0, ovf=0, last-grant ptr=N-1 (first search starts at 0).
//  load = !out_valid || out_ready. cand = pending | in_req.
//  On load with cand!=0: pick first set bit of cand searching from ptr+1 mod N
//   upward with wrap; out_idx<=pick, out_valid<=1, ptr<=pick, pick bit not kept.
//  On load with cand==0: out_valid<=0, out_idx holds last value.
//  No load (valid && !ready): out_valid, out_idx stable; pending |= in_req.
//  Latency: isolated in_req pulse at edge t -> out_valid=1 after edge t+1.
//  Pending next = (pending & ~grant_onehot) | in_req; set wins: an in_req bit
//   equal to the bit granted this cycle is retained as pending (new event).
//   Exception: when that bit is granted only via in_req (not previously pending),
//   the event is consumed by the grant and not re-queued.
//  ovf <= 1 when any in_req[i] && pending[i] && !(grant of i this cycle);
//   clr_ovf clears; simultaneous set and clear -> set wins.
//  pend_cnt reflects pending after the edge; max N, never wraps.
//  No state machine beyond the output register; throughput 1 index/cycle.
// STRUCTURE
//  action_pkg: N_ACTIONS=16, ACT_IDX_W=4, shared with the decoder.
//  Sub-module rr_pick (combinational): req[N], ptr[IDX_W] -> found, idx
//   (double-width mask/priority or rotate-then-priority-encode).
//  Top: pending reg, output reg, ptr reg, ovf reg, popcount.
// TESTING
//  1 Reset mid-stream: 5 bits pending, out_valid=1, drop rst_n -> all outputs 0
//    asynchronously; after release first grant of new pulse 16'h0004 is idx 2.
//  2 Single: ready=1, in_req=16'h0020 one cycle -> next cycle valid=1 idx=5,
//    following cycle valid=0, pend_cnt=0.
//  3 Round robin: ptr=5 (after granting 5), pulse 16'h0041, ready=1 -> idx 6
//    then idx 0; pulse 16'h8001 after -> idx 15 then 0.
//  4 Backpressure: ready=0, pulse 16'hFFFF -> idx held stable 20 cycles,
//    pend_cnt=15; then ready=1 -> 15 more indices, each exactly once, in wrap order.
//  5 Overflow: ready=0, bit 2 pulsed twice while pending -> ovf=1, idx 2
//    granted once; clr_ovf pulse -> ovf=0; clr_ovf with new loss -> ovf=1.
//  6 Set-wins: in_req[3] asserted in the cycle pending bit 3 is granted ->
//    idx 3 emitted twice, ovf stays 0.

Source files
------------

// File: rtl/action_pkg.sv
// Shared action-space constants for the action decoder and the action encoder.
package action_pkg;
  localparam int N_ACTIONS = 16;
  localparam int ACT_IDX_W = $clog2(N_ACTIONS);

  typedef logic [ACT_IDX_W-1:0] act_idx_t;
endpackage

// File: rtl/action_encoder_rr_pick.sv
// Round-robin picker: first set bit of req at or above ptr+1, wrapping modulo N.
module rr_pick #(
  parameter  int N     = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   shift;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate so bit ptr+1 lands at position 0, then take the lowest set bit.
  always_comb begin
    shift = {1'b0, ptr} + 1'b1;
    dbl   = {req, req} >> shift;
    rot   = dbl[N-1:0];
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    found = |req;
    idx   = ptr + 1'b1 + off;
  end

endmodule

// File: rtl/action_encoder.sv
// Collects per-action event pulses as sticky pending bits and streams them out
// one action index at a time with round-robin fairness.
module action_encoder
  import action_pkg::*;
#(
  parameter  int N     = N_ACTIONS,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   pend_cnt,
  output logic             ovf,
  input  logic             clr_ovf
);

  // Stream handshake: out_idx transfers on a rising edge where out_valid &&
  // out_ready; while out_valid && !out_ready, out_valid and out_idx hold.
  logic [N-1:0]     pending;
  logic [N-1:0]     cand;
  logic [N-1:0]     grant;
  logic [N-1:0]     pending_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   cnt_nxt;
  logic             found;
  logic             load;
  logic             lost;

  rr_pick #(.N(N)) u_pick (
    .req   (cand),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    load  = !out_valid || out_ready;
    cand  = pending | in_req;
    grant = '0;
    if (load && found) grant[pick] = 1'b1;
    // A fresh event is consumed by its own grant; a repeat of a pending one is requeued.
    pending_nxt = (pending & ~grant) | (in_req & ~(grant & ~pending));
    lost        = |(in_req & pending & ~grant);
    cnt_nxt     = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt = cnt_nxt + (IDX_W + 1)'(pending_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_cnt  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= IDX_W'(N - 1);
      ovf       <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
      if (load) begin
        out_valid <= found;
        if (found) begin
          out_idx <= pick;
          ptr     <= pick;
        end
      end
      if (lost) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_action_encoder.sv
// Bench for action_encoder: directed scenarios plus a random run against a
// cycle-level reference model of the pending/round-robin rules.
module tb_action_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [4:0]  pend_cnt;
  logic        ovf;
  logic        clr_ovf;

  int checks;
  int failures;

  // reference model state
  bit m_pend[16];
  int m_ptr;
  bit m_valid;
  int m_idx;
  bit m_ovf;

  logic [3:0] exp_q[$];

  action_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += m_pend[i];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_ptr   = 15;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ovf   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample at edge+1.
  task automatic step(input logic [15:0] req, input bit rdy, input bit clr);
    bit load;
    bit lost;
    int g;
    bit nxt[16];
    in_req    = req;
    out_ready = rdy;
    clr_ovf   = clr;
    load = !m_valid || rdy;
    g    = -1;
    if (load) begin
      for (int k = 1; k <= 16; k++) begin
        int j;
        j = (m_ptr + k) % 16;
        if (g < 0 && (m_pend[j] || req[j])) g = j;
      end
    end
    lost = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nxt[i] = (m_pend[i] && i != g) || (req[i] && (i != g || m_pend[i]));
      if (req[i] && m_pend[i] && i != g) lost = 1'b1;
    end
    @(posedge clk);
    #1;
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_idx   = g;
        m_ptr   = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++) m_pend[i] = nxt[i];
    m_ovf = lost ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  task automatic test_reset();
    step(16'h0001, 1'b0, 1'b0);
    step(16'h003E, 1'b0, 1'b0);
    checks++;
    if (pend_cnt !== 5'd5 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup: pend_cnt=%0d valid=%0b, expected 5/1", pend_cnt, out_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 4'd0 || pend_cnt !== 5'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: valid=%0b idx=%0d cnt=%0d ovf=%0b, expected all 0",
               out_valid, out_idx, pend_cnt, ovf);
    end
    in_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(16'h0004, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd2) begin
      failures++;
      $display("FAIL reset_first_grant: valid=%0b idx=%0d, expected 1/2", out_valid, out_idx);
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain: valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_single();
    step(16'h0020, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd5) begin
      failures++;
      $display("FAIL single_grant: valid=%0b idx=%0d, expected 1/5", out_valid, out_idx);
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || pend_cnt !== 5'd0) begin
      failures++;
      $display("FAIL single_after: valid=%0b cnt=%0d, expected 0/0", out_valid, pend_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] pulses[2];
    int          want[2][2];
    pulses[0] = 16'h0041;
    pulses[1] = 16'h8001;
    want[0][0] = 6;  want[0][1] = 0;
    want[1][0] = 15; want[1][1] = 0;
    for (int p = 0; p < 2; p++) begin
      step(pulses[p], 1'b1, 1'b0);
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== want[p][n][3:0]) begin
          failures++;
          $display("FAIL rr_order: pulse %h grant %0d valid=%0b idx=%0d, expected 1/%0d",
                   pulses[p], n, out_valid, out_idx, want[p][n]);
        end
        step(16'h0000, 1'b1, 1'b0);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle: valid=%0b, expected 0", out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen[16];
    int first;
    bit held_ok;
    first = (m_ptr + 1) % 16;
    step(16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== first[3:0] || pend_cnt !== 5'd15) begin
      failures++;
      $display("FAIL bp_load: valid=%0b idx=%0d cnt=%0d, expected 1/%0d/15",
               out_valid, out_idx, pend_cnt, first);
    end
    held_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(16'h0000, 1'b0, 1'b0);
      if (out_valid !== 1'b1 || out_idx !== first[3:0] || pend_cnt !== 5'd15) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL bp_hold: idx=%0d cnt=%0d, expected %0d/15 held", out_idx, pend_cnt, first);
    end
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    seen[first] = 1'b1;
    for (int k = 1; k < 16; k++) exp_q.push_back(4'((first + k) % 16));
    for (int k = 1; k < 16; k++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      step(16'h0000, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== e || seen[out_idx]) begin
        failures++;
        $display("FAIL bp_drain: step %0d valid=%0b idx=%0d, expected 1/%0d (unique)",
                 k, out_valid, out_idx, e);
      end
      if (out_valid === 1'b1) seen[out_idx] = 1'b1;
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || pend_cnt !== 5'd0) begin
      failures++;
      $display("FAIL bp_empty: valid=%0b cnt=%0d, expected 0/0", out_valid, pend_cnt);
    end
  endtask

  task automatic test_overflow();
    step(16'h0200, 1'b0, 1'b0);
    step(16'h0004, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b0 || pend_cnt !== 5'd1) begin
      failures++;
      $display("FAIL ovf_first: ovf=%0b cnt=%0d, expected 0/1", ovf, pend_cnt);
    end
    step(16'h0004, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || pend_cnt !== 5'd1) begin
      failures++;
      $display("FAIL ovf_set: ovf=%0b cnt=%0d, expected 1/1", ovf, pend_cnt);
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd2) begin
      failures++;
      $display("FAIL ovf_grant: valid=%0b idx=%0d, expected 1/2", out_valid, out_idx);
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_once: valid=%0b idx=%0d, expected 0", out_valid, out_idx);
    end
    step(16'h0000, 1'b1, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%0b, expected 0", ovf);
    end
    step(16'h0100, 1'b0, 1'b0);
    step(16'h0010, 1'b0, 1'b0);
    step(16'h0010, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: ovf=%0b, expected 1", ovf);
    end
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_set_wins();
    step(16'h0040, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0008, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd3 || pend_cnt !== 5'd1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL setwins_first: valid=%0b idx=%0d cnt=%0d ovf=%0b, expected 1/3/1/0",
               out_valid, out_idx, pend_cnt, ovf);
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd3 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL setwins_second: valid=%0b idx=%0d ovf=%0b, expected 1/3/0",
               out_valid, out_idx, ovf);
    end
    step(16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || pend_cnt !== 5'd0) begin
      failures++;
      $display("FAIL setwins_drain: valid=%0b cnt=%0d, expected 0/0", out_valid, pend_cnt);
    end
  endtask

  task automatic test_random();
    int bad;
    for (int c = 0; c < 600; c++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 2) != 0) r = r & 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      bad = 0;
      checks++;
      if (out_valid !== m_valid) bad++;
      if (out_idx !== m_idx[3:0]) bad++;
      if (pend_cnt !== 5'(m_count())) bad++;
      if (ovf !== m_ovf) bad++;
      if (bad != 0) begin
        failures++;
        $display("FAIL random c%0d: valid=%0b idx=%0d cnt=%0d ovf=%0b, expected %0b/%0d/%0d/%0b",
                 c, out_valid, out_idx, pend_cnt, ovf, m_valid, m_idx, m_count(), m_ovf);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_req    = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_set_wins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
